cmp_seq_ctrl: RTL and testbench
===============================

// Module: cmp_seq_ctrl
// PURPOSE
//  Sequencing controller for a bit-serial equality comparator. Captures two W-bit
//  operands on a start request and scans them MSB->LSB, one bit per clock, through a
//  single shared 1-bit XNOR compare cell. It stops at the first mismatch.
//  It then reports the result through a start/done handshake to the surrounding datapath.
// PARAMETERS
//  W   4   operand width in bits; legal range W >= 1
// PORTS
//  clk     in   1  single clock; all state changes on the rising edge
//  rst_n   in   1  synchronous, active-low reset, sampled on the clk rising edge
//  start   in   1  request a compare; accepted only while busy=0
//  a       in   W  operand A; sampled only on the accepting edge
//  b       in   W  operand B; sampled only on the accepting edge
//  busy    out  1  high in SCAN and DONE; start is ignored while high
//  done    out  1  one-cycle pulse; the result is valid from this cycle
//  equal   out  1  1 = a==b; held until the next accepted start
// BEHAVIOUR
//  - Reset (rst_n=0 at an edge): state=IDLE; busy=0, done=0, equal=0; operand and index
//    registers are cleared. This applies in any state, including mid-SCAN: the pending
//    compare is abandoned and no done pulse is issued.
//  - FSM states: IDLE, SCAN, DONE. All outputs are registered.
//  - IDLE: on an edge with start=1, capture a->ra and b->rb, set idx=W-1, clear equal
//    (and gt/lt), and go to SCAN. With start=0, stay in IDLE.
//  - SCAN: each edge evaluates m = cell(ra[idx], rb[idx]).
//      m=0               -> equal=0, go to DONE (early exit)
//      m=1 and idx==0    -> equal=1, go to DONE
//      m=1 and idx>0     -> idx=idx-1, stay in SCAN
//  - DONE: done=1 for exactly this one cycle; the next edge returns to IDLE.
//    A start pulse seen in DONE is dropped, not queued.
//  - Latency: let the accepting edge be E0 and let k be the number of bits examined
//    (1..W). done is high in the cycle after edge E0+k. A full match takes k=W.
//    Back-to-back compares are separated by a minimum of one IDLE cycle.
//  - Changing a and b after E0 has no effect on the current compare.
//  - idx width is max(1,$clog2(W)). idx never wraps: the idx==0 check exits first.
// CONFIGURATION
//  CMP_SEQ_MAG_EN defined:
//    - Adds two output ports, gt and lt (1 bit each), which reset to 0.
//    - On the first mismatch: gt=ra[idx] and lt=rb[idx].
//    - On a full match: gt=lt=0.
//    - Timing and hold behaviour match equal.
//  CMP_SEQ_MAG_EN undefined:
//    - gt and lt ports and logic are absent.
//    - Only the equality result is produced; the FSM is identical.
// STRUCTURE
//  - Shared package cmp_pkg:
//    - state encoding typedef cmp_state_t (IDLE=2'd0, SCAN=2'd1, DONE=2'd2);
//    - localparam CMP_IDX_W(W) helper.
//  - Sub-module cmp_bit_cell: out = a XNOR b.
//    - Instantiated exactly once, muxed by idx.
//    - This is the shared resource the controller sequences.
//  - The FSM, operand registers and index counter live in this module.
// TESTING (W=4, with and without CMP_SEQ_MAG_EN)
//  1. Hold rst_n=0 for 2 edges
//     -> busy=0, done=0, equal=0 (gt=lt=0).
//  2. start with a=1000, b=1000
//     -> done in cycle after E0+4; equal=1, gt=lt=0.
//  3. start with a=0101, b=1101
//     -> mismatch at bit3, done in cycle after E0+1; equal=0, lt=1, gt=0.
//  4. start with a=0001, b=0000
//     -> done in cycle after E0+4; equal=0, gt=1.
//  5. During case 2, pulse start with a=0000, b=1111 at E0+2
//     -> ignored; result is still equal=1; the next start from IDLE is accepted.
//  6. In case 4, drop rst_n at E0+2
//     -> IDLE after that edge; no done pulse; equal=0.
//     A following start with a=b=0011 gives equal=1.

Source files
------------

// File: rtl/cmp_pkg.sv
// Shared definitions for the bit-serial equality comparator controller:
// state encoding and the index-width helper.
package cmp_pkg;

  typedef logic [1:0] cmp_state_t;

  localparam cmp_state_t ST_IDLE = 2'd0;
  localparam cmp_state_t ST_SCAN = 2'd1;
  localparam cmp_state_t ST_DONE = 2'd2;

  // Index counter width; a one-bit operand still needs a one-bit index.
  function automatic int unsigned CMP_IDX_W(input int unsigned w);
    return (w <= 1) ? 1 : $clog2(w);
  endfunction

endpackage

// File: rtl/cmp_bit_cell.sv
// Single-bit XNOR compare cell; the one shared resource the controller sequences.
module cmp_bit_cell (
  input  logic a_i,
  input  logic b_i,
  output logic out_c
);

  assign out_c = ~(a_i ^ b_i);

endmodule

// File: rtl/cmp_seq_ctrl.sv
// Bit-serial equality comparator controller: scans two captured operands MSB->LSB
// through one shared compare cell. Define CMP_SEQ_MAG_EN to add gt/lt outputs.
module cmp_seq_ctrl
  import cmp_pkg::*;
#(
  parameter int unsigned W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic         busy,
  output logic         done,
  output logic         equal
`ifdef CMP_SEQ_MAG_EN
  ,
  output logic         gt,
  output logic         lt
`endif
);

  localparam int unsigned IDX_W = CMP_IDX_W(W);

  cmp_state_t       state_q, state_d;
  logic [W-1:0]     ra_q, ra_d;
  logic [W-1:0]     rb_q, rb_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             equal_q, equal_d;
  logic             match_c;
`ifdef CMP_SEQ_MAG_EN
  logic             gt_q, gt_d;
  logic             lt_q, lt_d;
`endif

  cmp_bit_cell u_cell (
    .a_i   (ra_q[idx_q]),
    .b_i   (rb_q[idx_q]),
    .out_c (match_c)
  );

  // Next-state and registered-output logic.
  always_comb begin
    state_d = state_q;
    ra_d    = ra_q;
    rb_d    = rb_q;
    idx_d   = idx_q;
    equal_d = equal_q;
`ifdef CMP_SEQ_MAG_EN
    gt_d    = gt_q;
    lt_d    = lt_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          ra_d    = a;
          rb_d    = b;
          idx_d   = IDX_W'(W - 1);
          equal_d = 1'b0;
`ifdef CMP_SEQ_MAG_EN
          gt_d    = 1'b0;
          lt_d    = 1'b0;
`endif
          state_d = ST_SCAN;
        end
      end
      ST_SCAN: begin
        if (!match_c) begin
          equal_d = 1'b0;
`ifdef CMP_SEQ_MAG_EN
          gt_d    = ra_q[idx_q];
          lt_d    = rb_q[idx_q];
`endif
          state_d = ST_DONE;
        end else if (idx_q == '0) begin
          equal_d = 1'b1;
          state_d = ST_DONE;
        end else begin
          idx_d = idx_q - IDX_W'(1);
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    busy_d = (state_d != ST_IDLE);
    done_d = (state_d == ST_DONE);
  end

  // Synchronous reset abandons any pending compare without a done pulse.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      ra_q    <= '0;
      rb_q    <= '0;
      idx_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      equal_q <= 1'b0;
`ifdef CMP_SEQ_MAG_EN
      gt_q    <= 1'b0;
      lt_q    <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      ra_q    <= ra_d;
      rb_q    <= rb_d;
      idx_q   <= idx_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      equal_q <= equal_d;
`ifdef CMP_SEQ_MAG_EN
      gt_q    <= gt_d;
      lt_q    <= lt_d;
`endif
    end
  end

  assign busy  = busy_q;
  assign done  = done_q;
  assign equal = equal_q;
`ifdef CMP_SEQ_MAG_EN
  assign gt    = gt_q;
  assign lt    = lt_q;
`endif

endmodule

// File: tb/tb_cmp_seq_ctrl.sv
// Self-checking bench for cmp_seq_ctrl (W=4); covers gt/lt when CMP_SEQ_MAG_EN is defined.
module tb_cmp_seq_ctrl;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic [W-1:0] a, b;
  logic         busy, done, equal;
`ifdef CMP_SEQ_MAG_EN
  logic         gt, lt;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  cmp_seq_ctrl #(.W(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .a     (a),
    .b     (b),
    .busy  (busy),
    .done  (done),
    .equal (equal)
`ifdef CMP_SEQ_MAG_EN
    ,
    .gt    (gt),
    .lt    (lt)
`endif
  );

  always #5 clk = ~clk;

  // Reference: bits examined = position of the most significant differing bit,
  // counted from the MSB; magnitude follows from ordinary unsigned comparison.
  function automatic void ref_model(input logic [W-1:0] ra, input logic [W-1:0] rb,
                                    output int k, output logic eq,
                                    output logic g, output logic l);
    int diff;
    diff = int'(ra ^ rb);
    eq   = (ra == rb);
    g    = (ra > rb);
    l    = (ra < rb);
    k    = eq ? W : W - ($clog2(diff + 1) - 1);
  endfunction

  // Present a request across one edge (E0), then scramble the operands.
  task automatic launch(input logic [W-1:0] va, input logic [W-1:0] vb);
    @(negedge clk);
    start = 1'b1;
    a     = va;
    b     = vb;
    @(posedge clk);
    #1;
    start = 1'b0;
    a     = W'($urandom);
    b     = W'($urandom);
  endtask

  // Edges after E0 until done is seen; -1 if it never appears within the budget.
  task automatic wait_done(output int cycles);
    cycles = -1;
    for (int n = 1; n <= W + 4; n++) begin
      @(posedge clk);
      #1;
      if (done) begin
        cycles = n;
        return;
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    start = 1'b0;
    a = '0;
    b = '0;
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if (busy !== 1'b0 || done !== 1'b0 || equal !== 1'b0) begin
      n_fail++;
      $display("FAIL reset: busy=%b done=%b equal=%b, want 0 0 0", busy, done, equal);
    end
`ifdef CMP_SEQ_MAG_EN
    n_checks++;
    if (gt !== 1'b0 || lt !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_mag: gt=%b lt=%b, want 0 0", gt, lt);
    end
`endif
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_directed();
    logic [W-1:0] va [3] = '{4'b1000, 4'b0101, 4'b0001};
    logic [W-1:0] vb [3] = '{4'b1000, 4'b1101, 4'b0000};
    int   exp_k  [3] = '{4, 1, 4};
    logic exp_eq [3] = '{1'b1, 1'b0, 1'b0};
    logic exp_gt [3] = '{1'b0, 1'b0, 1'b1};
    logic exp_lt [3] = '{1'b0, 1'b1, 1'b0};
    int cyc;
    for (int i = 0; i < 3; i++) begin
      launch(va[i], vb[i]);
      n_checks++;
      if (busy !== 1'b1 || done !== 1'b0) begin
        n_fail++;
        $display("FAIL directed%0d_accept: busy=%b done=%b, want 1 0", i, busy, done);
      end
      wait_done(cyc);
      n_checks++;
      if (cyc !== exp_k[i] || equal !== exp_eq[i]) begin
        n_fail++;
        $display("FAIL directed%0d_result: latency=%0d equal=%b, want %0d %b",
                 i, cyc, equal, exp_k[i], exp_eq[i]);
      end
`ifdef CMP_SEQ_MAG_EN
      n_checks++;
      if (gt !== exp_gt[i] || lt !== exp_lt[i]) begin
        n_fail++;
        $display("FAIL directed%0d_mag: gt=%b lt=%b, want %b %b", i, gt, lt, exp_gt[i], exp_lt[i]);
      end
`endif
      @(posedge clk);
      #1;
      n_checks++;
      if (busy !== 1'b0 || done !== 1'b0 || equal !== exp_eq[i]) begin
        n_fail++;
        $display("FAIL directed%0d_idle: busy=%b done=%b equal=%b, want 0 0 %b",
                 i, busy, done, equal, exp_eq[i]);
      end
    end
  endtask

  task automatic test_start_while_busy();
    int cyc = -1;
    launch(4'b1000, 4'b1000);
    for (int n = 1; n <= W + 4 && cyc < 0; n++) begin
      if (n == 2) begin
        start = 1'b1;
        a = 4'b0000;
        b = 4'b1111;
      end
      @(posedge clk);
      #1;
      start = 1'b0;
      if (done) cyc = n;
    end
    n_checks++;
    if (cyc !== W || equal !== 1'b1) begin
      n_fail++;
      $display("FAIL busy_ignore: latency=%0d equal=%b, want %0d 1", cyc, equal, W);
    end
    @(posedge clk);
    #1;
    launch(4'b0000, 4'b1111);
    wait_done(cyc);
    n_checks++;
    if (cyc !== 1 || equal !== 1'b0) begin
      n_fail++;
      $display("FAIL busy_next: latency=%0d equal=%b, want 1 0", cyc, equal);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset_mid_scan();
    int cyc;
    logic seen_done = 1'b0;
    launch(4'b0001, 4'b0000);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    n_checks++;
    if (busy !== 1'b0 || done !== 1'b0 || equal !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_mid: busy=%b done=%b equal=%b, want 0 0 0", busy, done, equal);
    end
    repeat (W + 2) begin
      @(posedge clk);
      #1;
      if (done || busy) seen_done = 1'b1;
    end
    n_checks++;
    if (seen_done !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_abandon: activity after reset=%b, want 0", seen_done);
    end
    launch(4'b0011, 4'b0011);
    wait_done(cyc);
    n_checks++;
    if (cyc !== W || equal !== 1'b1) begin
      n_fail++;
      $display("FAIL rst_recover: latency=%0d equal=%b, want %0d 1", cyc, equal, W);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_back_to_back();
    int cyc;
    launch(4'b1010, 4'b1011);
    wait_done(cyc);
    // start asserted while in DONE must be dropped
    start = 1'b1;
    a = 4'b1111;
    b = 4'b1111;
    @(posedge clk);
    #1;
    start = 1'b0;
    n_checks++;
    if (busy !== 1'b0 || equal !== 1'b0 || cyc !== W) begin
      n_fail++;
      $display("FAIL done_drop: busy=%b equal=%b latency=%0d, want 0 0 %0d", busy, equal, cyc, W);
    end
    @(posedge clk);
    #1;
    n_checks++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL done_noqueue: busy=%b, want 0", busy);
    end
    launch(4'b1111, 4'b1111);
    wait_done(cyc);
    n_checks++;
    if (cyc !== W || equal !== 1'b1) begin
      n_fail++;
      $display("FAIL b2b_second: latency=%0d equal=%b, want %0d 1", cyc, equal, W);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_random();
    logic [W-1:0] va, vb;
    int k, cyc;
    logic eq, g, l;
    for (int i = 0; i < 40; i++) begin
      va = W'($urandom);
      vb = ($urandom_range(0, 2) == 0) ? va : W'($urandom);
      ref_model(va, vb, k, eq, g, l);
      launch(va, vb);
      wait_done(cyc);
      n_checks++;
      if (cyc !== k || equal !== eq) begin
        n_fail++;
        $display("FAIL rand%0d a=%b b=%b: latency=%0d equal=%b, want %0d %b",
                 i, va, vb, cyc, equal, k, eq);
      end
`ifdef CMP_SEQ_MAG_EN
      n_checks++;
      if (gt !== g || lt !== l) begin
        n_fail++;
        $display("FAIL rand%0d_mag a=%b b=%b: gt=%b lt=%b, want %b %b", i, va, vb, gt, lt, g, l);
      end
`endif
      @(posedge clk);
      #1;
      n_checks++;
      if (done !== 1'b0 || busy !== 1'b0 || equal !== eq) begin
        n_fail++;
        $display("FAIL rand%0d_idle: done=%b busy=%b equal=%b, want 0 0 %b", i, done, busy, equal, eq);
      end
      repeat ($urandom_range(0, 2)) @(posedge clk);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_directed();
    test_start_while_busy();
    test_reset_mid_scan();
    test_back_to_back();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
